// File: rtl/uart_cmd_link.sv
// UART command link: 8N1 receiver assembling 3-byte commands,
// plus 8N1 transmitter for single-byte responses.
module uart_cmd_link #(
  parameter int BAUD_DIV     = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_ovr,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);
  localparam int TO_MAX = TIMEOUT_BITS * BAUD_DIV;
  localparam int TOW = $clog2(TO_MAX + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_MAX - 1);
  localparam logic [TOW-1:0] TO_ONE = TOW'(1);

  logic          rx_m, rx_s;
  state_t        rx_st, rx_nx;
  logic [11:0]   rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_ferr;
  logic          rx_tick, rx_half;
  logic          start_det, byte_ok, byte_bad;
  logic [1:0]    byte_cnt;
  logic [15:0]   shadow;
  logic [TOW-1:0] to_cnt;
  logic          to_run, to_hit;
  logic          done, load;

  state_t        tx_st, tx_nx;
  logic [11:0]   tx_cnt;
  logic [3:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick, tx_go;

  assign rx_tick = (rx_cnt == FULL);
  assign rx_half = (rx_cnt == HALF);
  assign tx_tick = (tx_cnt == FULL);

  // two-flop synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_st <= S_IDLE;
    else        rx_st <= rx_nx;
  end

  // RX next state; a framing error parks in STOP until the line is high
  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      S_IDLE:  if (!rx_s) rx_nx = S_START;
      S_START: if (rx_half) rx_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == 4'd7) rx_nx = S_STOP;
      S_STOP: begin
        if (rx_ferr) begin
          if (rx_s) rx_nx = S_IDLE;
        end else if (rx_tick && rx_s) begin
          rx_nx = S_IDLE;
        end
      end
      default: rx_nx = S_IDLE;
    endcase
  end

  // RX decoded events
  always_comb begin
    start_det = (rx_st == S_IDLE) && !rx_s;
    byte_ok   = (rx_st == S_STOP) && !rx_ferr && rx_tick && rx_s;
    byte_bad  = (rx_st == S_STOP) && !rx_ferr && rx_tick && !rx_s;
  end

  // RX baud counter, bit counter, shifter, framing flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_ferr <= 1'b0;
    end else begin
      if (rx_st == S_IDLE || rx_st != rx_nx ||
          (rx_st == S_DATA && rx_tick))
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 12'd1;
      if (rx_st == S_START)
        rx_bit <= '0;
      else if (rx_st == S_DATA && rx_tick)
        rx_bit <= rx_bit + 4'd1;
      if (rx_st == S_DATA && rx_tick)
        rx_sh <= {rx_s, rx_sh[7:1]};
      if (byte_bad)
        rx_ferr <= 1'b1;
      else if (rx_nx == S_IDLE)
        rx_ferr <= 1'b0;
    end
  end

  assign to_run = (byte_cnt != 2'd0) && (rx_st == S_IDLE) && !start_det;
  assign to_hit = to_run && (to_cnt == TO_LAST);
  assign done   = byte_ok && (byte_cnt == 2'd2);
  assign load   = done && (!cmd_rdy || clr_cmd_rdy);

  // byte assembly with inter-byte timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      shadow   <= '0;
      to_cnt   <= '0;
    end else begin
      if (byte_bad || to_hit) begin
        byte_cnt <= '0;
      end else if (byte_ok) begin
        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
        shadow   <= {shadow[7:0], rx_sh};
      end
      to_cnt <= (to_run && !to_hit) ? to_cnt + TO_ONE : '0;
    end
  end

  // command hand-off; completion beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      cmd_ovr <= 1'b0;
    end else begin
      if (load) cmd <= {shadow, rx_sh};
      if (load)             cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      cmd_ovr <= done && !load;
    end
  end

  assign tx_go = send_resp &&
                 ((tx_st == S_IDLE) || (tx_st == S_STOP && tx_tick));

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_st <= S_IDLE;
    else        tx_st <= tx_nx;
  end

  // TX next state; a request on the last stop cycle chains frames
  always_comb begin
    tx_nx = tx_st;
    unique case (tx_st)
      S_IDLE:  if (send_resp) tx_nx = S_START;
      S_START: if (tx_tick) tx_nx = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 4'd7) tx_nx = S_STOP;
      S_STOP:  if (tx_tick) tx_nx = send_resp ? S_START : S_IDLE;
      default: tx_nx = S_IDLE;
    endcase
  end

  // TX counters and shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      if (tx_st == S_IDLE || tx_st != tx_nx ||
          (tx_st == S_DATA && tx_tick))
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 12'd1;
      if (tx_st == S_START)
        tx_bit <= '0;
      else if (tx_st == S_DATA && tx_tick)
        tx_bit <= tx_bit + 4'd1;
      if (tx_go)
        tx_sh <= resp_data;
      else if (tx_st == S_DATA && tx_tick)
        tx_sh <= {1'b0, tx_sh[7:1]};
    end
  end

  // TX outputs from state
  always_comb begin
    TX        = 1'b1;
    tx_busy   = (tx_st != S_IDLE);
    resp_sent = (tx_st == S_STOP) && tx_tick;
    unique case (1'b1)
      (tx_st == S_START): TX = 1'b0;
      (tx_st == S_DATA):  TX = tx_sh[0];
      default:            TX = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed plus randomized bench for uart_cmd_link
// at BAUD_DIV=16, TIMEOUT_BITS=20.
module tb_uart_cmd_link;

  localparam int BD = 16;
  localparam int TB = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        cmd_ovr;
  logic [7:0]  resp_data = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;
  logic        tx_busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ovr_count = 0;
  int rdy_rise = 0;
  logic rdy_q = 1'b0;

  uart_cmd_link #(.BAUD_DIV(BD), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd_ovr(cmd_ovr), .resp_data(resp_data),
    .send_resp(send_resp), .resp_sent(resp_sent),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_ovr === 1'b1) ovr_count <= ovr_count + 1;
    if (cmd_rdy === 1'b1 && rdy_q !== 1'b1) rdy_rise <= cyc;
    rdy_q <= cmd_rdy;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic send_cmd(input logic [23:0] c);
    send_byte(c[23:16], 1'b1);
    idle_bits(1);
    send_byte(c[15:8], 1'b1);
    idle_bits(1);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // Caller has raised send_resp in this cycle (cycle 1 of the frame).
  // Frame bit j occupies cycles 2+16j .. 17+16j; resp_sent on cycle 161.
  task automatic run_tx(input logic [7:0] d, input logic chain,
                        input logic [7:0] nd, input string tag);
    logic [9:0] f;
    int bad;
    int sent_at;
    int pulses;
    f = {1'b1, d, 1'b0};
    bad = 0;
    sent_at = 0;
    pulses = 0;
    for (int k = 2; k <= 161; k++) begin
      @(negedge clk);
      if (k == 2) send_resp = 1'b0;
      if (k == 50) begin
        send_resp = 1'b1;
        resp_data = 8'hFF;
      end
      if (k == 51) send_resp = 1'b0;
      if (TX !== f[(k - 2) / BD] || tx_busy !== 1'b1) bad++;
      if (resp_sent === 1'b1) begin
        pulses++;
        if (sent_at == 0) sent_at = k;
      end
      if (k == 161 && chain) begin
        send_resp = 1'b1;
        resp_data = nd;
      end
    end
    check({tag, "_wave_errs"}, 32'(bad), 32'd0);
    check({tag, "_sent_cycle"}, 32'(sent_at), 32'd161);
    check({tag, "_sent_pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int t0;
    int lat;
    int o0;
    int gap;
    logic [7:0] b;
    logic [7:0] pend[$];
    logic [23:0] exp_cmd;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_ovr", 32'(cmd_ovr), 32'd0);
    check("rst_sent", 32'(resp_sent), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    send_byte(8'h12, 1'b1);
    idle_bits(1);
    send_byte(8'h34, 1'b1);
    idle_bits(1);
    t0 = cyc;
    send_byte(8'h56, 1'b1);
    check("t1_cmd", 32'(cmd), 32'h123456);
    check("t1_rdy", 32'(cmd_rdy), 32'd1);
    lat = rdy_rise - t0;
    check("t1_rdy_in_stop_bit",
          32'(lat >= 145 && lat <= 160), 32'd1);
    pulse_clr();
    check("clr_rdy", 32'(cmd_rdy), 32'd0);
    check("clr_cmd_kept", 32'(cmd), 32'h123456);

    send_resp = 1'b1;
    resp_data = 8'hA5;
    run_tx(8'hA5, 1'b1, 8'h3C, "tx_a5");
    run_tx(8'h3C, 1'b0, 8'h00, "tx_3c");
    @(negedge clk);
    check("tx_end_busy", 32'(tx_busy), 32'd0);
    check("tx_end_line", 32'(TX), 32'd1);

    idle_bits(1);
    send_cmd(24'h123456);
    check("ovr_pre_rdy", 32'(cmd_rdy), 32'd1);
    o0 = ovr_count;
    send_cmd(24'hAABBCC);
    idle_bits(1);
    check("ovr_pulses", 32'(ovr_count - o0), 32'd1);
    check("ovr_cmd_kept", 32'(cmd), 32'h123456);
    check("ovr_rdy", 32'(cmd_rdy), 32'd1);

    o0 = ovr_count;
    send_byte(8'hAA, 1'b1);
    idle_bits(1);
    send_byte(8'hBB, 1'b1);
    idle_bits(1);
    fork
      send_byte(8'hCC, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
      end
    join
    idle_bits(1);
    check("coinc_cmd", 32'(cmd), 32'hAABBCC);
    check("coinc_rdy", 32'(cmd_rdy), 32'd1);
    check("coinc_no_ovr", 32'(ovr_count - o0), 32'd0);
    pulse_clr();

    send_byte(8'h01, 1'b1);
    idle_bits(1);
    send_byte(8'h02, 1'b1);
    idle_bits(TB);
    send_cmd(24'h0A0B0C);
    check("timeout_cmd", 32'(cmd), 32'h0A0B0C);
    check("timeout_rdy", 32'(cmd_rdy), 32'd1);
    pulse_clr();

    send_byte(8'h55, 1'b1);
    idle_bits(1);
    send_byte(8'h77, 1'b0);
    idle_bits(2);
    check("ferr_no_rdy", 32'(cmd_rdy), 32'd0);
    send_cmd(24'h112233);
    check("ferr_cmd", 32'(cmd), 32'h112233);
    pulse_clr();

    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    idle_bits(2);
    send_cmd(24'hC0FFEE);
    check("glitch_cmd", 32'(cmd), 32'hC0FFEE);
    pulse_clr();

    fork
      begin
        for (int n = 0; n < 4; n++) begin
          logic [7:0] r;
          r = 8'($urandom);
          send_resp = 1'b1;
          resp_data = r;
          run_tx(r, 1'b0, 8'h00, "tx_rand");
          repeat ($urandom_range(1, 20)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          gap = ($urandom_range(0, 3) == 0) ? TB + 4 : $urandom_range(0, 3);
          b = 8'($urandom);
          idle_bits(gap);
          if (gap >= TB) pend.delete();
          send_byte(b, 1'b1);
          pend.push_back(b);
          if (pend.size() == 3) begin
            exp_cmd = {pend[0], pend[1], pend[2]};
            pend.delete();
            check("rand_cmd", 32'(cmd), 32'(exp_cmd));
            check("rand_rdy", 32'(cmd_rdy), 32'd1);
            pulse_clr();
          end
        end
        idle_bits(TB + 4);
      end
    join

    send_cmd(24'h9E3701);
    check("rstmid_pre_rdy", 32'(cmd_rdy), 32'd1);
    send_byte(8'h11, 1'b1);
    idle_bits(1);
    send_byte(8'h22, 1'b1);
    send_resp = 1'b1;
    resp_data = 8'h5A;
    @(negedge clk);
    send_resp = 1'b0;
    repeat (60) @(negedge clk);
    check("rstmid_pre_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", 32'(TX), 32'd1);
    check("rstmid_busy", 32'(tx_busy), 32'd0);
    check("rstmid_rdy", 32'(cmd_rdy), 32'd0);
    check("rstmid_cmd", 32'(cmd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_cmd(24'h445566);
    check("rstmid_post_cmd", 32'(cmd), 32'h445566);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
